// File: rtl/ddr_tx_serializer.sv
// DDR transmit serializer: buffers word pairs in a small FIFO and drives the
// rise word during the clk-high phase and the fall word during the clk-low phase.
module ddr_tx_serializer #(
  parameter int                WIDTH      = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0]  IDLE_VALUE = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WIDTH-1:0]              s_data_rise,
  input  logic [WIDTH-1:0]              s_data_fall,
  output logic [WIDTH-1:0]              ddr_data,
  output logic                          ddr_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   beat_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_rise [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_fall [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_pre;
  logic [WIDTH-1:0] fall_q;
  logic             valid_q;
  logic             valid_fall_q;

  // Ready depends only on the registered level, never on this cycle's pop.
  assign s_ready = (fifo_level < DEPTH_L);
  assign push    = s_valid && s_ready;
  assign pop     = enable && (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rise[wr_ptr] <= s_data_rise;
      mem_fall[wr_ptr] <= s_data_fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rise_q     <= IDLE_VALUE;
      fall_pre   <= IDLE_VALUE;
      valid_q    <= 1'b0;
      underrun   <= 1'b0;
      beat_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      // A burst broken by an empty FIFO, not by enable dropping.
      underrun <= valid_q && enable && (fifo_level == '0);
      if (pop) begin
        rise_q     <= mem_rise[rd_ptr];
        fall_pre   <= mem_fall[rd_ptr];
        valid_q    <= 1'b1;
        beat_count <= beat_count + 16'd1;
      end else begin
        rise_q   <= IDLE_VALUE;
        fall_pre <= IDLE_VALUE;
        valid_q  <= 1'b0;
      end
    end
  end

  // Retime the fall word so it only changes at the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q       <= IDLE_VALUE;
      valid_fall_q <= 1'b0;
    end else begin
      fall_q       <= fall_pre;
      valid_fall_q <= valid_q;
    end
  end

  assign ddr_data  = clk ? rise_q  : fall_q;
  assign ddr_valid = clk ? valid_q : valid_fall_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Self-checking bench for ddr_tx_serializer: table-driven single pairs, a
// streaming scoreboard monitor, and hand-written back-pressure/underrun/reset cases.
module tb_ddr_tx_serializer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data_rise;
  logic [7:0]  s_data_fall;
  logic [7:0]  ddr_data;
  logic        ddr_valid;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic [15:0] beat_count;

  int errors = 0;
  int checks = 0;
  int exp_beats = 0;
  bit mon_on = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
  } vec_t;

  vec_t vecs[4];

  ddr_tx_serializer #(.WIDTH(8), .FIFO_DEPTH(4), .IDLE_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_rise(s_data_rise), .s_data_fall(s_data_fall), .ddr_data(ddr_data),
    .ddr_valid(ddr_valid), .fifo_level(fifo_level), .underrun(underrun),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one pair for one edge; called at posedge+1, returns at the next posedge+1.
  task automatic apply_stimulus(input logic [7:0] r, input logic [7:0] f, output logic acc);
    s_valid     = 1'b1;
    s_data_rise = r;
    s_data_fall = f;
    acc         = s_ready;
    if (acc) sb.push_back({r, f});
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // One pair into an idle FIFO with enable high, then the trailing underrun.
  task automatic single_pair(input vec_t v);
    logic acc;
    enable = 1'b1;
    apply_stimulus(v.rise, v.fall, acc);
    check_output("single_accept", acc, 1);
    @(posedge clk); #2;
    exp_beats++;
    check_output("single_hi", ddr_data, v.exp_hi);
    check_output("single_valid_hi", ddr_valid, 1);
    check_output("single_beats", beat_count, exp_beats);
    @(negedge clk); #2;
    check_output("single_lo", ddr_data, v.exp_lo);
    check_output("single_valid_lo", ddr_valid, 1);
    @(posedge clk); #2;
    check_output("single_underrun", underrun, 1);
    check_output("single_idle_valid", ddr_valid, 0);
    check_output("single_idle_data", ddr_data, 8'h00);
    @(posedge clk); #1;
    check_output("single_underrun_clear", underrun, 0);
  endtask

  // Scoreboard monitor: pops an expected pair for every valid beat it sees.
  always begin
    logic [15:0] cur;
    logic        pend;
    @(posedge clk); #2;
    pend = 1'b0;
    cur  = '0;
    if (mon_on) begin
      if (ddr_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected_beat: got 0x%0h expected no beat at %0t", ddr_data, $time);
        end else begin
          cur  = sb.pop_front();
          pend = 1'b1;
          check_output("sb_rise", ddr_data, cur[15:8]);
        end
      end else begin
        check_output("sb_idle_hi", ddr_data, 8'h00);
      end
    end
    @(negedge clk); #2;
    if (mon_on && rst_n) begin
      check_output("sb_valid_lo", ddr_valid, pend);
      check_output("sb_fall", ddr_data, pend ? cur[7:0] : 8'h00);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic acc;
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0;
    s_data_rise = '0; s_data_fall = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1;
    check_output("rst_ready", s_ready, 1);
    check_output("rst_level", fifo_level, 0);
    check_output("rst_beats", beat_count, 0);
    check_output("rst_valid_hi", ddr_valid, 0);
    check_output("rst_data_hi", ddr_data, 8'h00);
    @(negedge clk); #1;
    check_output("rst_valid_lo", ddr_valid, 0);
    check_output("rst_data_lo", ddr_data, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) single_pair(vecs[i]);

    // Back-to-back stream: no gaps, no underrun until it ends.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(8'(2*i+1), 8'(2*i+2), acc);
      check_output("stream_accept", acc, 1);
      if (i >= 1) begin
        check_output("stream_valid", ddr_valid, 1);
        check_output("stream_no_underrun", underrun, 0);
      end
    end
    @(posedge clk); #1;
    check_output("stream_last_valid", ddr_valid, 1);
    check_output("stream_last_no_underrun", underrun, 0);
    @(posedge clk); #1;
    exp_beats += 10;
    check_output("stream_end_underrun", underrun, 1);
    check_output("stream_beats", beat_count, exp_beats);
    @(posedge clk); #1;

    // Enable low: fill to full, fifth pair refused, outputs idle.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(8'(8'h41 + 2*i), 8'(8'h42 + 2*i), acc);
      check_output("fill_accept", acc, (i < 4) ? 1 : 0);
      check_output("fill_idle_valid", ddr_valid, 0);
    end
    check_output("fill_level", fifo_level, 4);
    check_output("fill_ready", s_ready, 0);
    check_output("fill_underrun", underrun, 0);
    enable = 1'b1;
    apply_stimulus(8'h99, 8'h66, acc);
    check_output("full_pop_no_push", acc, 0);
    check_output("full_pop_level", fifo_level, 3);
    check_output("drain_valid0", ddr_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("drain_valid", ddr_valid, 1);
      check_output("drain_no_underrun", underrun, 0);
    end
    @(posedge clk); #1;
    exp_beats += 4;
    check_output("drain_underrun", underrun, 1);
    check_output("drain_level", fifo_level, 0);
    check_output("drain_beats", beat_count, exp_beats);
    @(posedge clk); #1;
    check_output("drain_underrun_once", underrun, 0);

    // Two-pair burst, one-cycle gap, then another pair.
    apply_stimulus(8'hB1, 8'hB2, acc);
    apply_stimulus(8'hB3, 8'hB4, acc);
    check_output("gap_valid_a", ddr_valid, 1);
    @(posedge clk); #1;
    check_output("gap_valid_b", ddr_valid, 1);
    check_output("gap_no_underrun", underrun, 0);
    apply_stimulus(8'hB5, 8'hB6, acc);
    check_output("gap_underrun", underrun, 1);
    check_output("gap_valid_low", ddr_valid, 0);
    @(posedge clk); #1;
    check_output("gap_underrun_clear", underrun, 0);
    check_output("gap_valid_c", ddr_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    exp_beats += 3;
    check_output("gap_beats", beat_count, exp_beats);

    // Reset in the low phase of a burst with three pairs still queued.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(8'(8'hD0 + i), 8'(8'hE0 + i), acc);
    enable = 1'b1;
    @(posedge clk); #1;
    check_output("mid_level", fifo_level, 3);
    check_output("mid_valid", ddr_valid, 1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    exp_beats = 0;
    check_output("mid_rst_data", ddr_data, 8'h00);
    check_output("mid_rst_valid", ddr_valid, 0);
    check_output("mid_rst_level", fifo_level, 0);
    check_output("mid_rst_ready", s_ready, 1);
    check_output("mid_rst_beats", beat_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    single_pair('{8'h77, 8'h88, 8'h77, 8'h88});

    repeat (2) @(posedge clk);
    #1;
    check_output("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
